// File: rtl/tt_sel_ctrl_if.sv
// Pad-side control inputs and spine-side select/enable outputs of the
// tiny-tapeout design selector, bundled for connection to tt_sel_ctrl.
interface tt_sel_ctrl_if;
  logic       ctrl_sel_inc;
  logic       ctrl_sel_clr;
  logic       ctrl_ena;
  logic [8:0] spine_sel;
  logic       spine_ena;
  logic       busy;

  modport master (
    output ctrl_sel_inc,
    output ctrl_sel_clr,
    output ctrl_ena,
    input  spine_sel,
    input  spine_ena,
    input  busy
  );

  modport slave (
    input  ctrl_sel_inc,
    input  ctrl_sel_clr,
    input  ctrl_ena,
    output spine_sel,
    output spine_ena,
    output busy
  );
endinterface

// File: rtl/tt_sel_ctrl.sv
// Design selector: synchronises pad controls, tracks a target address and
// moves the spine mux to it with break-before-make guard intervals.
module tt_sel_ctrl #(
  parameter int GUARD_CYC = 4
) (
  input logic        clk,
  input logic        rst,
  tt_sel_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ACTIVE,
    DROP,
    UPDATE,
    SETTLE
  } state_t;

  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYC - 1);

  logic       inc_s1, inc_s2;
  logic       clr_s1, clr_s2;
  logic       ena_s1, ena_s2;
  logic       inc_s, clr_s, ena_s;
  logic       inc_d;
  logic       primed;
  logic       armed;
  logic       inc_evt;

  logic [8:0] tgt;
  logic [8:0] cur;
  logic [8:0] cur_nx;
  logic [3:0] gcnt;
  logic [3:0] gcnt_nx;
  state_t     state;
  state_t     state_nx;
  logic       spine_ena_q;
  logic       spine_ena_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_s1 <= 1'b0;
      inc_s2 <= 1'b0;
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
      ena_s1 <= 1'b0;
      ena_s2 <= 1'b0;
    end else begin
      inc_s1 <= bus.ctrl_sel_inc;
      inc_s2 <= inc_s1;
      clr_s1 <= bus.ctrl_sel_clr;
      clr_s2 <= clr_s1;
      ena_s1 <= bus.ctrl_ena;
      ena_s2 <= ena_s1;
    end
  end

  assign inc_s = inc_s2;
  assign clr_s = clr_s2;
  assign ena_s = ena_s2;

  // Edge detection is only armed once the pad has been seen low after reset,
  // so an inc level already high at reset release never counts as an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_d  <= 1'b0;
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      inc_d  <= inc_s;
      primed <= 1'b1;
      armed  <= armed | (primed & ~inc_s1);
    end
  end

  assign inc_evt = inc_s & ~inc_d & armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt <= '0;
    end else if (clr_s) begin
      tgt <= '0;
    end else if (inc_evt) begin
      tgt <= tgt + 9'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACTIVE;
      gcnt        <= '0;
      cur         <= '0;
      spine_ena_q <= 1'b0;
    end else begin
      state       <= state_nx;
      gcnt        <= gcnt_nx;
      cur         <= cur_nx;
      spine_ena_q <= spine_ena_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gcnt_nx  = gcnt;
    cur_nx   = cur;
    case (state)
      ACTIVE: begin
        if (tgt != cur) begin
          state_nx = DROP;
          gcnt_nx  = GUARD_INIT;
        end
      end
      DROP: begin
        if (gcnt == 4'd0) begin
          state_nx = UPDATE;
        end else begin
          gcnt_nx = gcnt - 4'd1;
        end
      end
      UPDATE: begin
        cur_nx   = tgt;
        state_nx = SETTLE;
        gcnt_nx  = GUARD_INIT;
      end
      SETTLE: begin
        if (gcnt == 4'd0) begin
          state_nx = ACTIVE;
        end else begin
          gcnt_nx = gcnt - 4'd1;
        end
      end
      default: begin
        state_nx = ACTIVE;
        gcnt_nx  = '0;
      end
    endcase
  end

  // Enable only when parked on the target, so it is low whenever cur can move.
  assign spine_ena_nx = (state == ACTIVE) && (tgt == cur) && ena_s;

  assign bus.spine_sel = cur;
  assign bus.spine_ena = spine_ena_q;
  assign bus.busy      = (state != ACTIVE);

endmodule

// File: doc/tt_sel_ctrl.md
TT_SEL_CTRL -- requirements
Module: tt_sel_ctrl

Interface
REQ-001 SHALL have parameter GUARD_CYC, default 4, range 1..15: number of cycles spine_ena is held low before and after a select change.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ctrl_sel_inc, input, 1 bit, asynchronous pad: each rising edge advances the target design address by 1.
REQ-005 SHALL have port ctrl_sel_clr, input, 1 bit, asynchronous pad: while high, forces the target address to 0.
REQ-006 SHALL have port ctrl_ena, input, 1 bit, asynchronous pad: global enable for the selected design.
REQ-007 SHALL have port spine_sel, output, 9 bits: mux select; [8:5] row address, [4:0] column group/position; registered.
REQ-008 SHALL have port spine_ena, output, 1 bit: spine/row enable; registered.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state != ACTIVE.

Function
REQ-010 SHALL synchronise each of ctrl_sel_inc, ctrl_sel_clr and ctrl_ena through 2 flops (s1, s2); the s2 outputs are inc_s, clr_s, ena_s.
REQ-011 SHALL detect an inc event as inc_s=1 while inc_d=0, where inc_d is inc_s delayed one cycle; every pulse of at least 2 cycles high and 2 cycles low SHALL count exactly once.
REQ-012 SHALL hold a 9-bit target tgt: clr_s=1 sets tgt<=0, otherwise an inc event sets tgt<=tgt+1 mod 512 (511 wraps to 0); clr has priority over a same-cycle inc; tgt updates in any state.
REQ-013 SHALL hold cur, the register driving spine_sel; cur changes only on leaving UPDATE, where cur<=tgt.
REQ-014 SHALL implement FSM states ACTIVE, DROP, UPDATE, SETTLE with a 4-bit guard counter gcnt.
REQ-015 ACTIVE: if tgt!=cur, go to DROP with gcnt<=GUARD_CYC-1; otherwise stay in ACTIVE.
REQ-016 DROP: decrement gcnt; at gcnt=0, go to UPDATE (DROP lasts exactly GUARD_CYC cycles).
REQ-017 UPDATE: lasts 1 cycle; cur<=tgt; go to SETTLE with gcnt<=GUARD_CYC-1.
REQ-018 SETTLE: decrement gcnt; at gcnt=0, go to ACTIVE; inc/clr events arriving in DROP/UPDATE/SETTLE only change tgt, and are picked up by the ACTIVE re-check (no event lost, no sequence aborted mid-way).
REQ-019 spine_ena register SHALL load (state==ACTIVE && tgt==cur && ena_s) each cycle, so spine_ena is 0 during every cycle spine_sel can change (break-before-make).
REQ-020 ena_s falling SHALL clear spine_ena one edge later without any state change; ena_s rising in ACTIVE with tgt==cur sets spine_ena one edge later.
REQ-021 Latency with no contention: pin rises before edge E0 -> tgt increments at E2 -> DROP at E3 (spine_ena=0 at E3) -> spine_sel updates at E4+GUARD_CYC -> spine_ena=1 at E5+2*GUARD_CYC (E8/E13 for GUARD_CYC=4).
REQ-022 clr_s held high with tgt==cur==0 SHALL cause no sequence.

Reset
REQ-023 While rst=1: sync flops, inc_d, tgt, cur, gcnt = 0; state=ACTIVE; spine_sel=0; spine_ena=0; busy=0.
REQ-024 rst asserted mid-sequence SHALL abort immediately to the reset values; after release, no pending event is replayed, and an inc level already high at release is not counted.

Verification
REQ-025 Reset, ctrl_ena=1, GUARD_CYC=4 -> spine_sel=0; spine_ena=1 by the 3rd edge after rst release; busy=0.
REQ-026 One inc pulse -> spine_ena low at E3; spine_sel 0->1 at E8; spine_ena high at E13; spine_ena=0 in every cycle in which spine_sel changes.
REQ-027 3 inc pulses spaced 4 cycles apart (2 high, 2 low), landing during a sequence -> at most 2 sequences; final spine_sel=3; spine_ena=1; no glitch.
REQ-028 tgt=511 plus one inc -> spine_sel=0 after the sequence; then clr and inc asserted in the same cycle -> tgt=0 and no sequence starts.
REQ-029 ctrl_ena toggled 1->0->1 while idle -> spine_ena follows with a 3-edge lag; spine_sel unchanged; busy=0.
REQ-030 rst asserted during SETTLE -> all outputs are reset values at once; after release, with no further pulses, spine_sel stays 0.
